// File: rtl/stream_tap_mux.sv
// Frame-aligned AXI-Stream debug tap: routes one of NUM_CH stage streams to the video output
// through a 2-entry skid buffer. Define STREAM_TAP_FRAME_CNT_EN to enable the frame counter.
module stream_tap_mux #(
    parameter int unsigned        NUM_CH     = 6,
    parameter int unsigned        SAMPLES    = 4,
    parameter int unsigned        DATA_WIDTH = 8,
    parameter int unsigned        SEL_WIDTH  = 4,
    parameter logic [NUM_CH-1:0]  GRAY_MASK  = 6'b111110
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic [NUM_CH*3*SAMPLES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]                      s_axis_tvalid,
    input  logic [NUM_CH-1:0]                      s_axis_tuser,
    input  logic [NUM_CH-1:0]                      s_axis_tlast,
    output logic [NUM_CH-1:0]                      s_axis_tready,
    output logic [3*SAMPLES*DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tuser,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    input  logic [SEL_WIDTH-1:0]                   sel,
    output logic [SEL_WIDTH-1:0]                   active_ch,
    output logic [15:0]                            frame_count
);

    localparam int unsigned BeatW = 3 * SAMPLES * DATA_WIDTH;
    localparam int unsigned GrayW = SAMPLES * DATA_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPending
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] active_q, active_d;
    logic [SEL_WIDTH-1:0] req_ch;
    logic                 req_in_range;

    logic [NUM_CH-1:0]    req_oh, act_oh, src_oh;
    logic                 req_valid, req_user;
    logic                 act_valid;
    logic                 push, use_req, pop, full;

    logic [BeatW-1:0]     ch_data [NUM_CH];
    logic [BeatW-1:0]     in_data;
    logic                 in_user, in_last;

    logic [BeatW-1:0]     buf_data_q [2];
    logic [1:0]           buf_user_q, buf_last_q;
    logic [1:0]           count_q;

    // Per-channel output formatting: gray channels fan each sample out to R, G and B.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BeatW-1:0] fmt_data;
        if (GRAY_MASK[c]) begin : g_gray
            logic unused_hi;
            assign unused_hi = ^s_axis_tdata[c*BeatW+GrayW +: BeatW-GrayW];
            for (genvar k = 0; k < SAMPLES; k++) begin : g_smp
                assign fmt_data[3*k*DATA_WIDTH +: 3*DATA_WIDTH] =
                    {3{s_axis_tdata[c*BeatW + k*DATA_WIDTH +: DATA_WIDTH]}};
            end
        end else begin : g_rgb
            assign fmt_data = s_axis_tdata[c*BeatW +: BeatW];
        end
        assign ch_data[c] = fmt_data;
    end

    assign req_in_range = 32'(sel) < NUM_CH;
    assign req_ch       = req_in_range ? sel : '0;
    assign full         = (count_q == 2'd2);
    assign pop          = (count_q != 2'd0) && m_axis_tready;

    always_comb begin
        req_oh = '0;
        act_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_oh[i] = (req_ch == SEL_WIDTH'(i));
            act_oh[i] = (active_q == SEL_WIDTH'(i));
        end
        req_valid = |(s_axis_tvalid & req_oh);
        req_user  = |(s_axis_tuser & req_oh);
        act_valid = |(s_axis_tvalid & act_oh);
    end

    // FSM: state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_user) state_d = StRun;
            end
            StRun: begin
                if (req_ch != active_q) state_d = StPending;
            end
            StPending: begin
                if (req_ch == active_q) begin
                    state_d = StRun;
                end else if (req_valid && req_user && !full) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs (buffer push, source select, ready)
    always_comb begin
        push          = 1'b0;
        use_req       = 1'b0;
        active_d      = active_q;
        s_axis_tready = '1;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_user) begin
                    push     = 1'b1;
                    use_req  = 1'b1;
                    active_d = req_ch;
                end
            end
            StRun: begin
                s_axis_tready = ~act_oh | {NUM_CH{~full}};
                push          = act_valid && !full;
            end
            StPending: begin
                s_axis_tready = ~act_oh | {NUM_CH{~full}};
                // A frame start on the requested channel wins; the old channel's beat is dropped.
                if (req_ch != active_q && req_valid && req_user && !full) begin
                    push     = 1'b1;
                    use_req  = 1'b1;
                    active_d = req_ch;
                end else begin
                    push = act_valid && !full;
                end
            end
            default: begin
                s_axis_tready = '1;
            end
        endcase
    end

    assign src_oh = use_req ? req_oh : act_oh;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_oh[i]) in_data = ch_data[i];
        end
        in_user = |(s_axis_tuser & src_oh);
        in_last = |(s_axis_tlast & src_oh);
    end

    // Skid buffer: entry 0 is the registered output head.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_user_q    <= '0;
            buf_last_q    <= '0;
            count_q       <= 2'd0;
        end else if (push && pop) begin
            if (count_q == 2'd1) begin
                buf_data_q[0] <= in_data;
                buf_user_q[0] <= in_user;
                buf_last_q[0] <= in_last;
            end else begin
                buf_data_q[0] <= buf_data_q[1];
                buf_user_q[0] <= buf_user_q[1];
                buf_last_q[0] <= buf_last_q[1];
                buf_data_q[1] <= in_data;
                buf_user_q[1] <= in_user;
                buf_last_q[1] <= in_last;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                buf_data_q[0] <= in_data;
                buf_user_q[0] <= in_user;
                buf_last_q[0] <= in_last;
            end else begin
                buf_data_q[1] <= in_data;
                buf_user_q[1] <= in_user;
                buf_last_q[1] <= in_last;
            end
            count_q <= count_q + 2'd1;
        end else if (pop) begin
            buf_data_q[0] <= buf_data_q[1];
            buf_user_q[0] <= buf_user_q[1];
            buf_last_q[0] <= buf_last_q[1];
            count_q       <= count_q - 2'd1;
        end
    end

    assign m_axis_tdata  = buf_data_q[0];
    assign m_axis_tuser  = buf_user_q[0];
    assign m_axis_tlast  = buf_last_q[0];
    assign m_axis_tvalid = (count_q != 2'd0);
    assign active_ch     = active_q;

`ifdef STREAM_TAP_FRAME_CNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count_q <= '0;
        end else if (active_d != active_q) begin
            frame_count_q <= '0;
        end else if (pop && m_axis_tuser) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

    property p_hold_stable;
        @(posedge aclk) disable iff (!aresetn)
            (m_axis_tvalid && !m_axis_tready) |=>
                (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tuser)
                 && $stable(m_axis_tlast));
    endproperty
    a_hold_stable: assert property (p_hold_stable);

    a_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(push && full && !pop));

endmodule

// File: tb/tb_stream_tap_mux.sv
// Self-checking bench for stream_tap_mux: scoreboard queue of expected output beats.
module tb_stream_tap_mux;

    localparam int NumCh = 6;
    localparam int BeatW = 96;
    localparam logic [5:0] GrayMask = 6'b111110;

    logic                   aclk;
    logic                   aresetn;
    logic [NumCh*BeatW-1:0] s_axis_tdata;
    logic [NumCh-1:0]       s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
    logic [BeatW-1:0]       m_axis_tdata;
    logic                   m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
    logic [3:0]             sel, active_ch;
    logic [15:0]            frame_count;

    int total = 0;
    int bad   = 0;
    logic [97:0] exp_q [$];

    stream_tap_mux dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .sel           (sel),
        .active_ch     (active_ch),
        .frame_count   (frame_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BeatW-1:0] expand(input int ch, input logic [BeatW-1:0] d);
        logic [BeatW-1:0] r;
        r = d;
        if (GrayMask[ch]) begin
            for (int k = 0; k < 4; k++) r[24*k +: 24] = {3{d[8*k +: 8]}};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // One beat on channel ch; waits (bounded) for ready, records it if it must reach the output.
    task automatic beat(input int ch, input logic [BeatW-1:0] d, input logic u, input logic l,
                        input logic fwd);
        int n;
        s_axis_tdata[ch*BeatW +: BeatW] = d;
        s_axis_tvalid[ch] = 1'b1;
        s_axis_tuser[ch]  = u;
        s_axis_tlast[ch]  = l;
        n = 0;
        while (!s_axis_tready[ch] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("rdy_timeout", {127'd0, s_axis_tready[ch]}, 128'd1);
        tick();
        if (fwd) exp_q.push_back({u, l, expand(ch, d)});
        s_axis_tvalid[ch] = 1'b0;
        s_axis_tuser[ch]  = 1'b0;
        s_axis_tlast[ch]  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {127'd0, m_axis_tvalid}, 128'd0);
            end else begin
                check("beat", {30'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                      {30'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [BeatW-1:0] d;
        logic             rdy;
        logic [15:0]      fc_exp;

        aresetn = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = '0;
        s_axis_tuser = '0;
        s_axis_tlast = '0;
        m_axis_tready = 1'b1;
        sel = 4'd1;
        repeat (3) tick();

        check("rst_valid", {127'd0, m_axis_tvalid}, 128'd0);
        check("rst_data", 128'(m_axis_tdata), 128'd0);
        check("rst_active", 128'(active_ch), 128'd0);
        check("rst_fcnt", 128'(frame_count), 128'd0);
        check("rst_ready", 128'(s_axis_tready), 128'h3f);
        aresetn = 1'b1;
        tick();

        // Gray replication and IDLE waits for frame start
        beat(1, 96'h11, 1'b0, 1'b0, 1'b0);
        check("idle_novalid", {127'd0, m_axis_tvalid}, 128'd0);
        beat(1, 96'h40302010, 1'b1, 1'b0, 1'b1);
        check("gray_data", 128'(m_axis_tdata), 128'h404040303030202020101010);
        check("gray_user", {127'd0, m_axis_tuser}, 128'd1);
        check("active_1", 128'(active_ch), 128'd1);
        for (int i = 0; i < 3; i++) beat(1, 96'(32'h01010101 * (i + 2)), 1'b0, i == 2, 1'b1);

        // Mid-frame switch request: old channel drains until the new frame start
        sel = 4'd4;
        for (int i = 0; i < 5; i++) beat(1, 96'(32'hA0 + i), 1'b0, i == 4, 1'b1);
        beat(4, 96'h55, 1'b0, 1'b0, 1'b0);
        check("pend_active", 128'(active_ch), 128'd1);
        beat(4, 96'hAA, 1'b1, 1'b0, 1'b1);
        check("active_4", 128'(active_ch), 128'd4);
        drain();

        // Backpressure: 2-entry buffer fills, then releases in order
        d = 96'h100;
        for (int c = 0; c < 10; c++) begin
            m_axis_tready = (c >= 4);
            s_axis_tdata[4*BeatW +: BeatW] = d;
            s_axis_tvalid[4] = 1'b1;
            rdy = s_axis_tready[4];
            if (c < 4) begin
                check("bp_act_rdy", {127'd0, rdy}, {127'd0, c < 2});
                check("bp_other_rdy", {127'd0, s_axis_tready[1]}, 128'd1);
            end
            if (c == 3) check("bp_valid", {127'd0, m_axis_tvalid}, 128'd1);
            tick();
            if (rdy) begin
                exp_q.push_back({2'b00, expand(4, d)});
                d = d + 96'h1;
            end
        end
        s_axis_tvalid[4] = 1'b0;
        drain();

        // Out-of-range select maps to RGB channel 0
        sel = 4'd9;
        tick();
        beat(0, 96'hFEDCBA9876543210_0F1E2D3C, 1'b1, 1'b0, 1'b1);
        check("active_0", 128'(active_ch), 128'd0);
        check("rgb_data", 128'(m_axis_tdata), 128'hFEDCBA9876543210_0F1E2D3C);
        beat(0, 96'h123456789ABCDEF0_11223344, 1'b0, 1'b1, 1'b1);
        drain();

        // Frame counter: three frames on ch2, then switch to ch3
        sel = 4'd2;
        tick();
        for (int f = 0; f < 3; f++) begin
            beat(2, 96'(32'h2000 + f), 1'b1, 1'b0, 1'b1);
            beat(2, 96'(32'h2100 + f), 1'b0, 1'b1, 1'b1);
        end
        drain();
`ifdef STREAM_TAP_FRAME_CNT_EN
        fc_exp = 16'd3;
`else
        fc_exp = 16'd0;
`endif
        check("fcnt_3", 128'(frame_count), 128'(fc_exp));
        sel = 4'd3;
        tick();
        beat(3, 96'h3333, 1'b1, 1'b0, 1'b1);
        check("fcnt_clear", 128'(frame_count), 128'd0);
        tick();
`ifdef STREAM_TAP_FRAME_CNT_EN
        fc_exp = 16'd1;
`else
        fc_exp = 16'd0;
`endif
        check("fcnt_1", 128'(frame_count), 128'(fc_exp));
        drain();

        // Asynchronous reset mid-line with data buffered
        m_axis_tready = 1'b0;
        beat(3, 96'h3401, 1'b0, 1'b0, 1'b0);
        beat(3, 96'h3402, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", {127'd0, m_axis_tvalid}, 128'd1);
        #2;
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        check("async_valid", {127'd0, m_axis_tvalid}, 128'd0);
        check("async_data", 128'(m_axis_tdata), 128'd0);
        check("async_active", 128'(active_ch), 128'd0);
        m_axis_tready = 1'b1;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        beat(3, 96'h3403, 1'b0, 1'b1, 1'b0);
        tick();
        check("post_rst_idle", {127'd0, m_axis_tvalid}, 128'd0);
        beat(3, 96'h3404, 1'b1, 1'b0, 1'b1);
        check("post_rst_active", 128'(active_ch), 128'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
